alu_multibyte_sequencer: RTL
============================

Name: alu_multibyte_sequencer

Overview:
- Sequences the shared 8-bit 74181 ALU pair to run one operation over operands up to NUM_BYTES bytes wide.
- Feeds one byte per step, LSB first, and chains each step's carry-out into the next step's carry-in.
- Accepts requests over a valid/ready handshake and returns the assembled result over a second valid/ready handshake.
- Sits between the SPI register file and the two-nibble ALU: it drives the ALU inputs and captures the ALU outputs.

Parameters:
- NUM_BYTES, 4: maximum operand width in bytes; must be ≥2.
- SETTLE_CYCLES, 0: extra wait cycles per byte before the ALU result is captured (0..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: clock enable; when low, all state is held.
- req_valid, input, 1: request valid.
- req_ready, output, 1: request accepted when req_valid and req_ready are both high.
- req_s, input, 4: ALU function select.
- req_m, input, 1: ALU mode (1 = logic).
- req_cin, input, 1: ALU carry-in for byte 0; raw 74181 polarity.
- req_len, input, $clog2(NUM_BYTES): number of bytes minus 1.
- req_a, input, 8*NUM_BYTES: operand A.
- req_b, input, 8*NUM_BYTES: operand B.
- alu_a, output, 8: A byte to the ALU.
- alu_b, output, 8: B byte to the ALU.
- alu_s, output, 4: function select to the ALU.
- alu_m, output, 1: mode to the ALU.
- alu_cn, output, 1: carry-in to the ALU.
- alu_f, input, 8: ALU result byte.
- alu_cout, input, 1: ALU carry-out (upper nibble cn4).
- alu_equal, input, 1: AND of both nibble equal outputs.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response accepted when rsp_valid and rsp_ready are both high.
- rsp_f, output, 8*NUM_BYTES: result; bytes above the requested length are 0.
- rsp_cout, output, 1: carry-out of the last byte.
- rsp_equal, output, 1: AND of alu_equal over all processed bytes.
- busy, output, 1: high in any state other than IDLE.
- op_count, output, 16: completed-operation counter (optional feature).

Behaviour:
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_f 0; rsp_cout 0; rsp_equal 0; busy 0; op_count 0. ALU drive outputs are all 0 except alu_cn = 1.
- All register updates are qualified by ena.
- ALU drive outputs are registered copies of the active byte. The ALU path is combinational, so alu_f is valid in the same cycle as the drive.
- IDLE:
  - req_ready = 1.
  - On a request handshake: latch A, B, s, m and len; set byte index = 0, alu_cn = req_cin, rsp_f = 0, equal accumulator = 1, wait counter = SETTLE_CYCLES. Go to RUN.
- RUN:
  - req_ready = 0.
  - Drive alu_a and alu_b from the latched operand byte at the current index.
  - While the wait counter is nonzero, decrement it.
  - When it reaches 0, capture:
    - alu_f into rsp_f byte[index];
    - alu_equal ANDed into the accumulator;
    - alu_cout into alu_cn for the next byte.
  - If index == len, go to DONE with rsp_cout = alu_cout. Otherwise increment index and reload the wait counter.
- DONE:
  - rsp_valid = 1. rsp_f, rsp_cout and rsp_equal are stable.
  - On a response handshake: rsp_valid drops, req_ready rises and the state returns to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake (no bypass).
- Latency: request handshake to rsp_valid = (len+1)*(SETTLE_CYCLES+1) cycles. Throughput is one operation per latency + 2 cycles.
- The index never exceeds len. A len value ≥ NUM_BYTES (possible only when NUM_BYTES is not a power of 2) is clamped to NUM_BYTES-1 at latch.
- req_valid during RUN or DONE is ignored (not accepted). The requester must hold its request until accepted.
- A rsp_ready stall holds DONE indefinitely with all outputs stable.
- ena low mid-operation freezes the index, wait counter and outputs. The sequence resumes unchanged when ena returns.
- rst_n asserted mid-operation aborts immediately to reset values. The partial result is discarded and no response is issued.
- Carry polarity is never interpreted; alu_cout is chained verbatim.

Optional Feature:
- Macro ALU_SEQ_OPCNT_EN.
- Defined: op_count increments by 1 on each response handshake and wraps from 0xFFFF to 0x0000; it is reset to 0.
- Undefined: op_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Add with carry chain: NUM_BYTES=4, SETTLE=0, s=1001, m=0, cin=1, len=1, A=0x00FF, B=0x0001 -> rsp_f=0x00000100, rsp_cout=1, rsp_valid exactly 2 cycles after the handshake.
- Full-width wrap: len=3, A=0xFFFFFFFF, B=0x00000001, add -> rsp_f=0x00000000, rsp_cout=0 (carry out).
- Compare: s=0110, m=0, cin=1, len=3, A=B=0x12345678 -> rsp_equal=1; repeat with B=0x12345679 -> rsp_equal=0.
- Settle and backpressure: SETTLE=2, len=0 -> rsp_valid 3 cycles after the handshake. Hold rsp_ready=0 for 10 cycles -> outputs stable and req_ready=0. Then a second request is accepted only after the response handshake.
- Reset and ena: deassert ena mid-RUN for 5 cycles -> the result is unchanged versus the uninterrupted run. Assert rst_n low mid-RUN -> all outputs at reset values and no rsp_valid.
- ALU_SEQ_OPCNT_EN defined: 3 completed operations -> op_count=3. Preload to 0xFFFF via 65535 operations or force -> the next operation yields 0.

Source files
------------

// File: rtl/alu_multibyte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_multibyte_sequencer
// Function : Steps a shared 8-bit 74181 ALU pair across a multi-byte operand,
//            LSB first, chaining carry between bytes. Optional completed-op
//            counter is built when ALU_SEQ_OPCNT_EN is defined.
// Revision : 1.0
// ============================================================================
module alu_multibyte_sequencer #(
    parameter int NUM_BYTES     = 4,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_s,
    input  logic                          req_m,
    input  logic                          req_cin,
    input  logic [$clog2(NUM_BYTES)-1:0]  req_len,
    input  logic [8*NUM_BYTES-1:0]        req_a,
    input  logic [8*NUM_BYTES-1:0]        req_b,
    output logic [7:0]                    alu_a,
    output logic [7:0]                    alu_b,
    output logic [3:0]                    alu_s,
    output logic                          alu_m,
    output logic                          alu_cn,
    input  logic [7:0]                    alu_f,
    input  logic                          alu_cout,
    input  logic                          alu_equal,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [8*NUM_BYTES-1:0]        rsp_f,
    output logic                          rsp_cout,
    output logic                          rsp_equal,
    output logic                          busy,
    output logic [15:0]                   op_count
);

    localparam int         IDX_W    = $clog2(NUM_BYTES);
    localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           r_len;
    logic [IDX_W-1:0]           w_len_clamped;
    logic [3:0]                 r_wait;
    // Byte 0 goes straight to the ALU drive at accept; only upper bytes are kept.
    logic [8*(NUM_BYTES-1)-1:0] r_a_hi;
    logic [8*(NUM_BYTES-1)-1:0] r_b_hi;
    logic                       r_eq;
    logic                       w_req_fire;
    logic                       w_capture;
    logic                       w_last;

    assign w_req_fire = (r_state == ST_IDLE) && req_valid;
    assign w_capture  = (r_state == ST_RUN) && (r_wait == 4'd0);
    assign w_last     = (r_idx == r_len);

    generate
        if ((1 << IDX_W) > NUM_BYTES) begin : g_len_clamp
            localparam logic [IDX_W-1:0] C_MAX_LEN = IDX_W'(NUM_BYTES - 1);
            assign w_len_clamped = (req_len > C_MAX_LEN) ? C_MAX_LEN : req_len;
        end else begin : g_len_direct
            assign w_len_clamped = req_len;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)             w_state_next = ST_RUN;
            ST_RUN:  if (w_capture && w_last)   w_state_next = ST_DONE;
            ST_DONE: if (rsp_ready)             w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Handshakes only take effect on cycles where ena is high.
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_equal = r_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_len    <= '0;
            r_wait   <= 4'd0;
            r_a_hi   <= '0;
            r_b_hi   <= '0;
            r_eq     <= 1'b0;
            alu_a    <= 8'd0;
            alu_b    <= 8'd0;
            alu_s    <= 4'd0;
            alu_m    <= 1'b0;
            alu_cn   <= 1'b1;
            rsp_f    <= '0;
            rsp_cout <= 1'b0;
        end else if (ena) begin
            if (w_req_fire) begin
                r_a_hi <= req_a[8*NUM_BYTES-1:8];
                r_b_hi <= req_b[8*NUM_BYTES-1:8];
                r_len  <= w_len_clamped;
                r_idx  <= '0;
                r_wait <= C_SETTLE;
                r_eq   <= 1'b1;
                alu_a  <= req_a[7:0];
                alu_b  <= req_b[7:0];
                alu_s  <= req_s;
                alu_m  <= req_m;
                alu_cn <= req_cin;
                rsp_f  <= '0;
            end else if (r_state == ST_RUN) begin
                if (!w_capture) begin
                    r_wait <= r_wait - 4'd1;
                end else begin
                    rsp_f[8*r_idx +: 8] <= alu_f;
                    r_eq                <= r_eq & alu_equal;
                    alu_cn              <= alu_cout;
                    if (w_last) begin
                        rsp_cout <= alu_cout;
                    end else begin
                        // Upper-byte store is offset by one, so r_idx selects byte r_idx+1.
                        r_idx  <= r_idx + IDX_W'(1);
                        r_wait <= C_SETTLE;
                        alu_a  <= r_a_hi[8*r_idx +: 8];
                        alu_b  <= r_b_hi[8*r_idx +: 8];
                    end
                end
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    logic        w_rsp_fire;
    logic [15:0] r_op_count;

    assign w_rsp_fire = (r_state == ST_DONE) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 16'd0;
        end else if (ena && w_rsp_fire) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = 16'd0;
`endif

endmodule
`default_nettype wire
